// File: rtl/acc_feeder_pkg.sv
// Shared types and defaults for the accumulator operand feeder.
// DATA_W_DEFAULT is also the accumulator's acc_in width.
package acc_feeder_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT  = 4;
  localparam int LEN_W_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/acc_feeder_if.sv
// Producer-to-feeder operand stream.
// Handshake: a word transfers on a rising clk edge where in_valid & in_ready;
// in_data must be stable while in_valid is high, and in_ready never depends on in_valid.
interface acc_feeder_if #(
  parameter int DATA_W = acc_feeder_pkg::DATA_W_DEFAULT
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/acc_feeder_fifo.sv
// Small synchronous FIFO; read data is the head entry (no write-to-read bypass).
module acc_feeder_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_feeder.sv
// Operand sequencer: buffers producer operands, then on start clears the
// accumulator and issues burst_len operands on acc_in, ending with a done pulse.
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  acc_feeder_if.slave       in_if,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [DATA_W-1:0] acc_in,
  output logic              done,
  output state_t            state_dbg,
  output logic [CW-1:0]     fifo_count_dbg
);

  state_t             state, state_next;
  logic [LEN_W-1:0]   cnt, cnt_next;
  logic [LEN_W-1:0]   len_q, len_next;
  logic               pop;
  logic               full, empty, push;
  logic [DATA_W-1:0]  rd_data;

  // in_ready is held low while reset is asserted even though the FIFO is empty.
  assign in_if.in_ready = rst & ~full;
  assign push           = in_if.in_valid & in_if.in_ready;

  acc_feeder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (in_if.in_data),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count_dbg),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      acc_en <= 1'b0;
      acc_in <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      len_q  <= len_next;
      acc_en <= pop;
      if (pop) acc_in <= rd_data;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_next   = len_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            len_next   = burst_len;
            cnt_next   = '0;
            state_next = CLEAR;
          end else begin
            state_next = DONE;
          end
        end
      end
      CLEAR: state_next = RUN;
      RUN: begin
        // An empty FIFO stalls the burst without popping.
        if (!empty) begin
          pop      = 1'b1;
          cnt_next = cnt + LEN_W'(1);
          if (cnt_next == len_q) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == CLEAR) || (state == RUN);
  assign acc_clr   = (state == CLEAR);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
